pipeline_scoreboard: RTL and testbench
======================================

Name: pipeline_scoreboard

Overview:
Parametrised hazard/forwarding controller for the in-order RISC-V pipeline. It tracks every in-flight register writer between ID and WB in a shift register of depth PIPE_DEPTH. Each cycle it gives the decode stage an interlock stall and a per-operand forwarding select. It also keeps saturating stall statistics. It sits beside the ID stage, sees the same busywait and branch/jump flush as the pipeline registers, and replaces the fixed-depth, forwarding-free behaviour of the current core.

Parameters:
- REG_ADDR_W, 5: register address width (32 architectural registers).
- PIPE_DEPTH, 3: tracked stages after ID. Entry 0 = EX, entry PIPE_DEPTH-1 = WB. Legal range 2..8.
- LOAD_READY_IDX, 1: first entry index at which load data can be forwarded (1 = MEM output). Must be < PIPE_DEPTH.
- CNT_W, 32: width of the statistics counters.
- FWD_W, derived: clog2(PIPE_DEPTH+1). Not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- busywait  in  1  pipeline hold (memory busywait); when high, all state holds
- flush  in  1  branch_or_jump_signal; squashes the instruction currently in ID
- issue_valid  in  1  ID stage holds a real instruction
- issue_rs1, issue_rs2  in  REG_ADDR_W  source register addresses
- issue_rs1_used, issue_rs2_used  in  1  the corresponding source is actually read
- issue_rd  in  REG_ADDR_W  destination register
- issue_wr_en  in  1  the instruction writes issue_rd
- issue_is_load  in  1  the instruction is a load
- stall_id  out  1  hold IF/ID and insert a bubble into ID/EX
- fwd_sel_rs1, fwd_sel_rs2  out  FWD_W  0 = register file; k = forward from entry k-1
- inflight  out  FWD_W  number of valid entries
- stall_count  out  CNT_W  cycles with stall_id=1 and busywait=0 (saturating)
- load_use_count  out  CNT_W  load-use stall cycles (saturating)

Behaviour:
- State: entries e[0..PIPE_DEPTH-1], each {valid, rd, is_load}, plus the two counters.
- Reset (synchronous, highest priority): all e[i].valid=0, rd=0, is_load=0, counters=0. Resulting outputs: stall_id=0, fwd_sel=0, inflight=0. Reset mid-stall or mid-busywait gives the same result next cycle.
- Advance rule, evaluated only when busywait=0:
  - e[i] <= e[i-1] for i≥1.
  - e[0] <= {1, issue_rd, issue_is_load} when issue_valid & issue_wr_en & (issue_rd≠0) & !stall_id & !flush.
  - Otherwise e[0] <= bubble (valid=0).
  - The WB entry drops out every advance. There is no other retirement path.
- busywait=1: all entries and counters hold. Flush and issue are ignored that cycle (the flush source holds its value across busywait).
- Lookup for operand s ∈ {rs1, rs2}:
  - Ignored (fwd_sel=0, no stall) if not used, s=0, or issue_valid=0.
  - Otherwise find the smallest i with e[i].valid & e[i].rd=s (youngest writer wins).
  - No match: fwd_sel=0.
  - Match with e[i].is_load & i<LOAD_READY_IDX: load-use hazard. Set hz_s=1 and fwd_sel=0.
  - Any other match: fwd_sel=i+1.
- stall_id = (hz_rs1 | hz_rs2) & !flush. Combinational from state and current inputs; no registered latency.
- The same-cycle WB write is covered by forwarding from entry PIPE_DEPTH-1. The register file's read-during-write ordering is irrelevant.
- Counters update only when busywait=0 and reset=0:
  - stall_count += stall_id.
  - load_use_count += stall_id (every stall is a load-use stall in this version; separate counters are kept for future causes).
  - Both saturate at 2^CNT_W-1, with no wrap.
- inflight = popcount(e[].valid). Combinational.
- Priority order: reset > busywait > flush > stall > issue.

Decomposition:
- Shared package pipeline_pkg:
  - constant REG_ADDR_W.
  - typedef sb_entry_t {valid, rd, is_load}.
  - constant FWD_REGFILE = 0.
  - function clog2.
- One sub-module, sb_match (combinational): entry vector + source address → {hit, fwd_sel, hazard}. Instantiated twice, for rs1 and rs2.
- Counters are inline.

Test Plan:
- Back-to-back ALU dependency: issue add x5 (no load); next cycle issue with rs1=5 → stall_id=0, fwd_sel_rs1=1; one cycle later, another rs1=5 consumer → fwd_sel_rs1=2.
- Load-use: issue lw x7; next cycle issue rs2=7 → stall_id=1 for exactly 1 cycle, then fwd_sel_rs2=2; stall_count=1 and load_use_count=1.
- x0 and unused sources: issue writer with rd=0; consumer rs1=0 → fwd_sel_rs1=0 and inflight unchanged. Also: rs2=match but issue_rs2_used=0 → fwd_sel_rs2=0.
- Youngest-wins: writers of x3 at e[2] and e[0] → fwd_sel=1. Fill all PIPE_DEPTH=3 entries, then idle 3 cycles → inflight goes 3,2,1,0.
- busywait + flush: lw x9 in e[0]; busywait=1 for 4 cycles → state and counters frozen, stall_id stays 1. Then busywait=0 with flush=1 → stall_id=0 and e[0] becomes a bubble.
- Saturation and reset: with CNT_W=4, hold a stall 20 cycles → stall_count=15. Assert reset for 1 cycle mid-stall → next cycle counters=0, inflight=0, stall_id=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
package pipeline_pkg;

  localparam int REG_ADDR_W  = 32'sd5;
  localparam int FWD_REGFILE = 32'sd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } sb_entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Looks up one source operand against the in-flight writers; the youngest
// matching writer decides between a forward select and a load-use hazard.
module sb_match
  import pipeline_pkg::*;
#(
  parameter int PIPE_DEPTH     = 3,
  parameter int LOAD_READY_IDX = 1,
  parameter int FWD_W          = 2
) (
  input  sb_entry_t [PIPE_DEPTH-1:0] entries,
  input  logic                       issue_valid,
  input  logic                       src_used,
  input  logic [REG_ADDR_W-1:0]      src,
  output logic                       hit,
  output logic                       hazard,
  output logic [FWD_W-1:0]           fwd_sel
);

  // Scan oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hazard  = 1'b0;
    fwd_sel = FWD_W'(FWD_REGFILE);
    if (issue_valid && src_used && (src != {REG_ADDR_W{1'b0}})) begin
      for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
        if (entries[i].valid && (entries[i].rd == src)) begin
          hit = 1'b1;
          if (entries[i].is_load && (i < LOAD_READY_IDX)) begin
            hazard  = 1'b1;
            fwd_sel = FWD_W'(FWD_REGFILE);
          end else begin
            hazard  = 1'b0;
            fwd_sel = FWD_W'(i + 1);
          end
        end else begin
          hit = hit;
        end
      end
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding controller beside ID: tracks in-flight writers from EX to WB,
// produces the load-use interlock, per-operand forward selects and stall statistics.
module pipeline_scoreboard #(
  parameter  int REG_ADDR_W     = 5,
  parameter  int PIPE_DEPTH     = 3,
  parameter  int LOAD_READY_IDX = 1,
  parameter  int CNT_W          = 32,
  localparam int FWD_W          = pipeline_pkg::clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  busywait,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_rs1_used,
  input  logic                  issue_rs2_used,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_wr_en,
  input  logic                  issue_is_load,
  output logic                  stall_id,
  output logic [FWD_W-1:0]      fwd_sel_rs1,
  output logic [FWD_W-1:0]      fwd_sel_rs2,
  output logic [FWD_W-1:0]      inflight,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      load_use_count
);
  import pipeline_pkg::*;

  sb_entry_t [PIPE_DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] load_use_count_q, load_use_count_d;

  logic             rs1_hit_s, rs1_hz_s, rs2_hit_s, rs2_hz_s;
  logic [FWD_W-1:0] rs1_fwd_s, rs2_fwd_s;

  sb_match #(
    .PIPE_DEPTH(PIPE_DEPTH), .LOAD_READY_IDX(LOAD_READY_IDX), .FWD_W(FWD_W)
  ) u_match_rs1 (
    .entries(entries_q), .issue_valid(issue_valid), .src_used(issue_rs1_used),
    .src(issue_rs1), .hit(rs1_hit_s), .hazard(rs1_hz_s), .fwd_sel(rs1_fwd_s)
  );

  sb_match #(
    .PIPE_DEPTH(PIPE_DEPTH), .LOAD_READY_IDX(LOAD_READY_IDX), .FWD_W(FWD_W)
  ) u_match_rs2 (
    .entries(entries_q), .issue_valid(issue_valid), .src_used(issue_rs2_used),
    .src(issue_rs2), .hit(rs2_hit_s), .hazard(rs2_hz_s), .fwd_sel(rs2_fwd_s)
  );

  // Interlock and forward selects are same-cycle so ID sees them without latency.
  always_comb begin
    stall_id    = (rs1_hz_s | rs2_hz_s) & ~flush;
    fwd_sel_rs1 = (rs1_hit_s && !rs1_hz_s) ? rs1_fwd_s : FWD_W'(FWD_REGFILE);
    fwd_sel_rs2 = (rs2_hit_s && !rs2_hz_s) ? rs2_fwd_s : FWD_W'(FWD_REGFILE);
  end

  // Population count of valid entries.
  always_comb begin
    inflight = {FWD_W{1'b0}};
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      inflight = inflight + FWD_W'(entries_q[i].valid);
    end
  end

  // Shift the tracker and bump saturating counters; everything holds under busywait.
  always_comb begin
    entries_d        = entries_q;
    stall_count_d    = stall_count_q;
    load_use_count_d = load_use_count_q;
    if (!busywait) begin
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        entries_d[i] = entries_q[i-1];
      end
      if (issue_valid && issue_wr_en && (issue_rd != {REG_ADDR_W{1'b0}}) &&
          !stall_id && !flush) begin
        entries_d[0] = {1'b1, issue_rd, issue_is_load};
      end else begin
        entries_d[0] = '0;
      end
      if (stall_id && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_count_d = stall_count_q;
      end
      if (stall_id && (load_use_count_q != {CNT_W{1'b1}})) begin
        load_use_count_d = load_use_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        load_use_count_d = load_use_count_q;
      end
    end else begin
      entries_d = entries_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q        <= '0;
      stall_count_q    <= {CNT_W{1'b0}};
      load_use_count_q <= {CNT_W{1'b0}};
    end else begin
      entries_q        <= entries_d;
      stall_count_q    <= stall_count_d;
      load_use_count_q <= load_use_count_d;
    end
  end

  assign stall_count    = stall_count_q;
  assign load_use_count = load_use_count_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed table-driven bench for pipeline_scoreboard (PIPE_DEPTH=3, CNT_W=4).
module tb_pipeline_scoreboard;

  localparam int CNT_W = 4;
  localparam int FWD_W = 2;

  logic             clk = 1'b0;
  logic             reset, busywait, flush, issue_valid;
  logic [4:0]       issue_rs1, issue_rs2, issue_rd;
  logic             issue_rs1_used, issue_rs2_used, issue_wr_en, issue_is_load;
  logic             stall_id;
  logic [FWD_W-1:0] fwd_sel_rs1, fwd_sel_rs2, inflight;
  logic [CNT_W-1:0] stall_count, load_use_count;

  always #5 clk = ~clk;

  pipeline_scoreboard #(
    .REG_ADDR_W(5), .PIPE_DEPTH(3), .LOAD_READY_IDX(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .busywait(busywait), .flush(flush),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_wr_en(issue_wr_en), .issue_is_load(issue_is_load),
    .stall_id(stall_id), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .inflight(inflight), .stall_count(stall_count), .load_use_count(load_use_count)
  );

  typedef struct {
    logic       iv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       bw;
    logic       fl;
    int         st;
    int         f1;
    int         f2;
    int         inf;
    int         sc;
    int         lc;
  } vec_t;

  vec_t tbl[18];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input int iv, input int rs1, input int u1, input int rs2,
                              input int u2, input int rd, input int we, input int ld,
                              input int bw, input int fl, input int st, input int f1,
                              input int f2, input int inf, input int sc, input int lc);
    vec_t v;
    v.iv = iv[0]; v.rs1 = rs1[4:0]; v.u1 = u1[0]; v.rs2 = rs2[4:0]; v.u2 = u2[0];
    v.rd = rd[4:0]; v.we = we[0]; v.ld = ld[0]; v.bw = bw[0]; v.fl = fl[0];
    v.st = st; v.f1 = f1; v.f2 = f2; v.inf = inf; v.sc = sc; v.lc = lc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, then clock.
  task automatic step(input vec_t v, input string tag);
    issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs1_used = v.u1;
    issue_rs2 = v.rs2; issue_rs2_used = v.u2; issue_rd = v.rd;
    issue_wr_en = v.we; issue_is_load = v.ld; busywait = v.bw; flush = v.fl;
    @(negedge clk);
    chk({tag, " stall_id"}, int'(stall_id), v.st);
    chk({tag, " fwd_sel_rs1"}, int'(fwd_sel_rs1), v.f1);
    chk({tag, " fwd_sel_rs2"}, int'(fwd_sel_rs2), v.f2);
    chk({tag, " inflight"}, int'(inflight), v.inf);
    chk({tag, " stall_count"}, int'(stall_count), v.sc);
    chk({tag, " load_use_count"}, int'(load_use_count), v.lc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sc;
    int exp_inf;
    int exp_f1;

    //            iv rs1 u1 rs2 u2 rd we ld bw fl  st f1 f2 inf sc lc
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  0, 1, 0, 1, 0, 0);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 1, 0, 0, 0,  0, 2, 0, 2, 0, 0);
    tbl[4]  = mk(1, 0, 1, 6, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0);
    tbl[5]  = mk(1, 6, 1, 6, 1, 0, 0, 0, 0, 0,  0, 3, 3, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 7, 1, 8, 1, 0, 0, 0,  0, 0, 2, 1, 1, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 2, 1, 1);
    tbl[10] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 0, 0, 2, 1, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 3, 1, 1);
    tbl[12] = mk(1, 3, 1, 4, 1, 0, 0, 0, 0, 0,  0, 1, 2, 3, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
    tbl[16] = mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 1,  0, 0, 0, 0, 1, 1);
    tbl[17] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);

    reset = 1'b1; busywait = 1'b0; flush = 1'b0; issue_valid = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; issue_wr_en = 1'b0; issue_is_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // Load x9 stalled behind busywait, then released together with a flush.
    step(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0,  0, 0, 0, 0, 1, 1), "bw_load");
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 9, 1, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 1, 1, 1), $sformatf("bw_hold%0d", k));
    end
    step(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1), "bw_flush");
    step(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 1, 1), "post_flush");

    // "lw x9, (x9)" every cycle: stalls on alternate cycles until counters saturate.
    exp_sc = 1;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) begin
        exp_f1 = 3; exp_inf = 1;
      end else if (k % 2 == 1) begin
        exp_f1 = 0; exp_inf = (k == 1) ? 1 : 2;
      end else begin
        exp_f1 = 2; exp_inf = 1;
      end
      step(mk(1, 9, 1, 0, 0, 9, 1, 1, 0, 0,  k % 2, exp_f1, 0, exp_inf, exp_sc, exp_sc),
           $sformatf("sat%0d", k));
      if ((k % 2 == 1) && (exp_sc < 15)) exp_sc++;
    end
    step(mk(1, 9, 1, 0, 0, 9, 1, 1, 0, 0,  0, 2, 0, 1, 15, 15), "sat_final");

    reset = 1'b1;
    step(mk(1, 9, 1, 0, 0, 9, 1, 1, 0, 0,  1, 0, 0, 2, 15, 15), "reset_mid_stall");
    reset = 1'b0;
    step(mk(1, 9, 1, 0, 0, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0), "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
